// File: rtl/ntt_shift_pkg.sv
// Shared constants, FSM state type and small helpers for the NTT data-path
// rotation blocks.
package ntt_shift_pkg;

   localparam int WIDTH   = 32;
   localparam int SIZE    = 257;
   localparam int SHIFT_W = 9;
   localparam int K_W     = $clog2(SHIFT_W);

   typedef enum logic [1:0] {
      IDLE,
      ROT,
      DONE
   } state_t;

   function automatic int word_lo(input int i);
      return i * WIDTH;
   endfunction

   // A single conditional subtract is enough because the largest shift is below 2*SIZE.
   function automatic logic [SHIFT_W-1:0] reduce_shift(input logic [SHIFT_W-1:0] s);
      if (s >= SHIFT_W'(SIZE)) begin
         return s - SHIFT_W'(SIZE);
      end
      return s;
   endfunction

endpackage

// File: rtl/circular_unshift_seq_rotr_stage.sv
// Combinational right rotation of a SIZE-word list by 2^k words, with a
// pass-through when the stage is disabled.
module rotr_stage
   import ntt_shift_pkg::*;
(
   input  logic [SIZE*WIDTH-1:0] data,
   input  logic [K_W-1:0]        k,
   input  logic                  enable,
   output logic [SIZE*WIDTH-1:0] result
);

   logic [SHIFT_W-1:0][SIZE*WIDTH-1:0] rot;

   // Every candidate amount is a fixed rewiring; word i takes word (i - 2^j) mod SIZE.
   for (genvar j = 0; j < SHIFT_W; j++) begin : g_amt
      for (genvar i = 0; i < SIZE; i++) begin : g_word
         localparam int SRC = (i + SIZE - (1 << j)) % SIZE;
         assign rot[j][word_lo(i) +: WIDTH] = data[word_lo(SRC) +: WIDTH];
      end
   end

   always_comb begin
      result = data;
      if (enable) begin
         for (int j = 0; j < SHIFT_W; j++) begin
            if (k == K_W'(j)) begin
               result = rot[j];
            end
         end
      end
   end

endmodule

// File: rtl/circular_unshift_seq.sv
// Sequential inverse of circular_shift: rotates the accepted list right by the
// reduced shift amount, one binary stage per clock, then holds the result.
module circular_unshift_seq
   import ntt_shift_pkg::*;
(
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [SIZE*WIDTH-1:0] in_list,
   input  logic [SHIFT_W-1:0]    in_shift,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SIZE*WIDTH-1:0] out_list
);

   state_t                state;
   logic [K_W-1:0]        k;
   logic [SHIFT_W-1:0]    shift_q;
   logic [SIZE*WIDTH-1:0] data_q;
   logic [SIZE*WIDTH-1:0] stage_out;

   rotr_stage u_rotr_stage (
      .data   (data_q),
      .k      (k),
      .enable (shift_q[k]),
      .result (stage_out)
   );

   // All SHIFT_W stages always run so latency does not depend on the shift.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state     <= IDLE;
         k         <= '0;
         shift_q   <= '0;
         data_q    <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  data_q   <= in_list;
                  shift_q  <= reduce_shift(in_shift);
                  k        <= '0;
                  in_ready <= 1'b0;
                  state    <= ROT;
               end
            end
            ROT: begin
               data_q <= stage_out;
               k      <= k + K_W'(1);
               if (k == K_W'(SHIFT_W - 1)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   assign out_list = data_q;

endmodule
